serializer_tx_arbiter: RTL and testbench
========================================

Name: serializer_tx_arbiter

Overview:
- Round-robin scheduler that shares one Aurora serializer among NUM_REQ packet sources (router output ports / host DMA).
- Captures the winning requester's 1024-bit payload and header fields and launches the serializer with a one-cycle send_data_valid pulse.
- Holds all serializer inputs stable until the job completes, then acknowledges the requester.
- Sits between the router crossbar outputs and the serializer feeding the Aurora TX AXIS port.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- SEND_DATA_WIDTH, 1024, payload width per request.
- ADDR_WIDTH, 10, destination address width.
- TIMEOUT_CYCLES, 64, completion watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester request level.
- req_data  in  NUM_REQ*SEND_DATA_WIDTH  payloads; requester i occupies slice [i*SEND_DATA_WIDTH +: SEND_DATA_WIDTH].
- req_dst_addr  in  NUM_REQ*ADDR_WIDTH  destination addresses.
- req_ttl  in  NUM_REQ*2  TTL per requester.
- req_router_id  in  NUM_REQ*2  router id per requester.
- req_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- grant  out  NUM_REQ  one-hot owner of the serializer; zero when idle.
- busy  out  1  high from launch until the end of RECOVER.
- send_data_valid  out  1  one-cycle launch strobe to the serializer.
- v_data_read  out  SEND_DATA_WIDTH  captured payload.
- dst_addr_send  out  ADDR_WIDTH  captured destination address.
- TTL_send  out  2  captured TTL.
- router_id_send  out  2  captured router id.
- done_serializer  in  1  serializer completion level (sticky high until the next header).

Behaviour:
- Reset: all outputs 0; state IDLE; rr_ptr = NUM_REQ-1, so requester 0 has first priority; done_d = 0.
- States: IDLE, WAIT, RECOVER.
- IDLE, when req != 0:
  - Winner = first set bit searching upward, with wrap, from rr_ptr+1.
  - At the clock edge: capture the winner's data, addr, ttl and router_id into the output registers; grant <= onehot(winner); rr_ptr <= winner; send_data_valid <= 1; busy <= 1; go to WAIT.
  - Latency: req seen high in cycle t -> send_data_valid high in cycle t+1.
- WAIT:
  - send_data_valid <= 0. It must never be high for more than one cycle, because the serializer re-latches its payload on every valid cycle.
  - Captured fields stay constant, since the serializer samples the header fields live.
  - Completion is the rising edge of done_serializer (done_serializer & ~done_d); the level alone is ignored because done stays high after completion.
  - On the rising edge: req_ack <= grant (one-cycle pulse); go to RECOVER.
- RECOVER:
  - One cycle. Clears grant and busy; req_ack returns to 0; go to IDLE.
  - Guarantees the serializer is back in its IDLE state before the next launch.
  - Minimum gap between done rising and the next send_data_valid is 3 cycles.
- Requester contract: hold req and its fields stable until req_ack; drop req in the cycle after ack, or keep it high to queue another packet. req is not sampled in WAIT or RECOVER.
- Fairness: with all requesters continuously high, grants rotate 0,1,2,3,0,...
- A requester that drops req before it is granted is simply skipped; there is no pending memory.
- done rising while in IDLE or RECOVER (spurious) is ignored.
- Reset asserted mid-WAIT aborts the job: no ack is issued and outputs clear immediately.

Optional Feature:
- SERARB_TIMEOUT_EN defined:
  - Adds output timeout_err (1 bit, one-cycle pulse) and a WAIT-cycle counter of width $clog2(TIMEOUT_CYCLES+1).
  - If no done rising edge is seen within TIMEOUT_CYCLES cycles of entering WAIT: pulse timeout_err, do NOT pulse req_ack, go to RECOVER; the requester retries on a later grant.
  - The counter clears on entering WAIT.
- SERARB_TIMEOUT_EN undefined: no port, no counter; WAIT lasts indefinitely until done rises.

Decomposition:
- Shared package serializer_pkg: SEND_DATA_WIDTH, ADDR_WIDTH, TTL/router-id widths (2), and the arbiter state encoding (IDLE=2'd0, WAIT=2'd1, RECOVER=2'd2).
- One sub-module rr_pick: purely combinational; inputs req and rr_ptr, outputs one-hot winner and its index.

Test Plan:
- Single request: req=4'b0100 with dst_addr=10'h155, ttl=2, router_id=1 -> send_data_valid high exactly one cycle, one cycle after req; grant=4'b0100; dst_addr_send=10'h155 held through WAIT; req_ack=4'b0100 one cycle after done rises.
- Fairness: req=4'b1111 held for 8 jobs -> grant order 0,1,2,3,0,1,2,3; each launch no sooner than 3 cycles after the previous done rise.
- Sticky done: keep done_serializer high from job 1 into job 2's WAIT, then drop and re-raise it -> job 2 acks only on the re-rise.
- Skip and wrap: rr_ptr=2, req=4'b0011 -> grant=4'b0001; then req=4'b0010 -> grant=4'b0010.
- Reset mid-WAIT: assert rst_n low 5 cycles after launch -> all outputs 0 at once, no req_ack; after release, req=4'b0001 -> grant 0.
- With SERARB_TIMEOUT_EN and TIMEOUT_CYCLES=64, done never asserted -> timeout_err pulses 64 cycles into WAIT, no req_ack, arbiter returns to IDLE.

Source files
------------

// File: rtl/serializer_pkg.sv
// serializer_pkg: shared widths and arbiter state encoding for the serializer TX path.
package serializer_pkg;
  localparam int SEND_DATA_WIDTH = 1024;
  localparam int ADDR_WIDTH = 10;
  localparam int TTL_WIDTH = 2;
  localparam int ROUTER_ID_WIDTH = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RECOVER = 2'd2} arb_state_t;
endpackage

// File: rtl/serializer_tx_arbiter_if.sv
// serializer_tx_arbiter_if: requester/serializer bus of the TX arbiter.
// timeout_err exists only when SERARB_TIMEOUT_EN is defined.
interface serializer_tx_arbiter_if import serializer_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int SEND_DATA_WIDTH = serializer_pkg::SEND_DATA_WIDTH,
  parameter int ADDR_WIDTH = serializer_pkg::ADDR_WIDTH
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ*SEND_DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_dst_addr;
  logic [NUM_REQ*TTL_WIDTH-1:0] req_ttl;
  logic [NUM_REQ*ROUTER_ID_WIDTH-1:0] req_router_id;
  logic [NUM_REQ-1:0] req_ack;
  logic [NUM_REQ-1:0] grant;
  logic busy;
  logic send_data_valid;
  logic [SEND_DATA_WIDTH-1:0] v_data_read;
  logic [ADDR_WIDTH-1:0] dst_addr_send;
  logic [TTL_WIDTH-1:0] TTL_send;
  logic [ROUTER_ID_WIDTH-1:0] router_id_send;
  logic done_serializer;
`ifdef SERARB_TIMEOUT_EN
  logic timeout_err;
`endif
  modport slave (
`ifdef SERARB_TIMEOUT_EN
    output timeout_err,
`endif
    input req, req_data, req_dst_addr, req_ttl, req_router_id, done_serializer,
    output req_ack, grant, busy, send_data_valid, v_data_read, dst_addr_send, TTL_send, router_id_send
  );
  modport master (
`ifdef SERARB_TIMEOUT_EN
    input timeout_err,
`endif
    output req, req_data, req_dst_addr, req_ttl, req_router_id, done_serializer,
    input req_ack, grant, busy, send_data_valid, v_data_read, dst_addr_send, TTL_send, router_id_send
  );
endinterface

// File: rtl/serializer_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin pick, searching upward with wrap from rr_ptr+1.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0] rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IW-1:0] win_idx
);
  always_comb begin
    win_idx = '0;
    winner = '0;
    for (int i = NUM_REQ; i >= 1; i--)
      win_idx = req[(int'(rr_ptr) + i) % NUM_REQ] ? IW'((int'(rr_ptr) + i) % NUM_REQ) : win_idx;
    winner[win_idx] = |req;
  end
endmodule

// File: rtl/serializer_tx_arbiter.sv
// serializer_tx_arbiter: round-robin launcher sharing one Aurora serializer among NUM_REQ sources.
// Define SERARB_TIMEOUT_EN to add a WAIT watchdog with a timeout_err pulse.
module serializer_tx_arbiter import serializer_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int SEND_DATA_WIDTH = serializer_pkg::SEND_DATA_WIDTH,
  parameter int ADDR_WIDTH = serializer_pkg::ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic clk,
  input logic rst_n,
  serializer_tx_arbiter_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  arb_state_t state;
  logic [IW-1:0] rr_ptr, win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic done_d, done_rise;
`ifdef SERARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;
`endif
  assign done_rise = bus.done_serializer & ~done_d;
  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .req(bus.req), .rr_ptr(rr_ptr), .winner(win_oh), .win_idx(win_idx)
  );
  // done is sticky high, so only its rising edge marks completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= IW'(NUM_REQ - 1);
      done_d <= 1'b0;
      bus.req_ack <= '0;
      bus.grant <= '0;
      bus.busy <= 1'b0;
      bus.send_data_valid <= 1'b0;
      bus.v_data_read <= '0;
      bus.dst_addr_send <= '0;
      bus.TTL_send <= '0;
      bus.router_id_send <= '0;
`ifdef SERARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      done_d <= bus.done_serializer;
      bus.send_data_valid <= 1'b0;
      bus.req_ack <= '0;
`ifdef SERARB_TIMEOUT_EN
      bus.timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: if (|bus.req) begin
          bus.v_data_read <= bus.req_data[win_idx*SEND_DATA_WIDTH +: SEND_DATA_WIDTH];
          bus.dst_addr_send <= bus.req_dst_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          bus.TTL_send <= bus.req_ttl[win_idx*TTL_WIDTH +: TTL_WIDTH];
          bus.router_id_send <= bus.req_router_id[win_idx*ROUTER_ID_WIDTH +: ROUTER_ID_WIDTH];
          bus.grant <= win_oh;
          rr_ptr <= win_idx;
          bus.send_data_valid <= 1'b1;
          bus.busy <= 1'b1;
          state <= WAIT;
`ifdef SERARB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: if (done_rise) begin
          bus.req_ack <= bus.grant;
          state <= RECOVER;
        end
`ifdef SERARB_TIMEOUT_EN
        else if (wait_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          bus.timeout_err <= 1'b1;
          state <= RECOVER;
        end else wait_cnt <= wait_cnt + CW'(1);
`endif
        RECOVER: begin
          bus.grant <= '0;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_serializer_tx_arbiter.sv
// tb_serializer_tx_arbiter: scoreboard bench for the round-robin serializer arbiter.
// Define SERARB_TIMEOUT_EN to also exercise the completion watchdog.
module tb_serializer_tx_arbiter;
  import serializer_pkg::*;
  localparam int N = 4;
  localparam int DW = SEND_DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  typedef struct {
    logic [N-1:0] grant;
    logic [AW-1:0] addr;
    logic [1:0] ttl;
    logic [1:0] rid;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serializer_tx_arbiter_if bus_if ();
  serializer_tx_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus_if));
  exp_t exp_q[$];
  exp_t e;
  int tests_run = 0, tests_failed = 0, cyc_cnt = 0, done_cyc = 0;
  logic [AW-1:0] held_addr;
  logic [DW-1:0] held_data;
  logic prev_sdv = 1'b0;
  bit ok;
  always @(posedge clk) cyc_cnt++;
  // scoreboard: every launch pops one expected job; fields must hold while busy
  always @(negedge clk) begin
    if (rst_n && bus_if.send_data_valid) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL launch_unexpected got grant=%b want no launch", bus_if.grant);
      end else begin
        e = exp_q.pop_front();
        if ({bus_if.grant, bus_if.dst_addr_send, bus_if.TTL_send, bus_if.router_id_send, bus_if.v_data_read} !==
            {e.grant, e.addr, e.ttl, e.rid, e.data}) begin
          tests_failed++;
          $display("FAIL launch_fields got g=%b a=%h t=%0d r=%0d d=%h want g=%b a=%h t=%0d r=%0d d=%h",
                   bus_if.grant, bus_if.dst_addr_send, bus_if.TTL_send, bus_if.router_id_send,
                   bus_if.v_data_read[31:0], e.grant, e.addr, e.ttl, e.rid, e.data[31:0]);
        end
      end
      held_addr = bus_if.dst_addr_send;
      held_data = bus_if.v_data_read;
    end else if (rst_n && bus_if.busy) begin
      tests_run++;
      if ({bus_if.dst_addr_send, bus_if.v_data_read} !== {held_addr, held_data}) begin
        tests_failed++;
        $display("FAIL hold_fields got a=%h d=%h want a=%h d=%h", bus_if.dst_addr_send,
                 bus_if.v_data_read[31:0], held_addr, held_data[31:0]);
      end
    end
    if (prev_sdv) begin
      tests_run++;
      if (bus_if.send_data_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL sdv_width got=%b want=0", bus_if.send_data_valid);
      end
    end
    prev_sdv = rst_n && bus_if.send_data_valid;
  end
  function automatic logic [DW-1:0] mk_data(input int i, input logic [AW-1:0] a);
    return {32{a, 2'(i), 20'hABCDE}};
  endfunction
  task automatic set_src(input int i, input logic [AW-1:0] a, input logic [1:0] t, input logic [1:0] r);
    bus_if.req_dst_addr[i*AW +: AW] = a;
    bus_if.req_ttl[i*2 +: 2] = t;
    bus_if.req_router_id[i*2 +: 2] = r;
    bus_if.req_data[i*DW +: DW] = mk_data(i, a);
  endtask
  task automatic push_exp(input int i, input logic [AW-1:0] a, input logic [1:0] t, input logic [1:0] r);
    exp_t x;
    x.grant = '0;
    x.grant[i] = 1'b1;
    x.addr = a;
    x.ttl = t;
    x.rid = r;
    x.data = mk_data(i, a);
    exp_q.push_back(x);
  endtask
  task automatic wait_launch(output bit found);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      found = bus_if.send_data_valid;
    end
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    bus_if.req = '0;
    bus_if.done_serializer = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic finish_job(input logic [N-1:0] exp_ack, input logic [N-1:0] req_after);
    if (bus_if.done_serializer) begin
      bus_if.done_serializer = 1'b0;
      @(negedge clk);
    end
    bus_if.done_serializer = 1'b1;
    done_cyc = cyc_cnt;
    @(negedge clk);
    tests_run++;
    if (bus_if.req_ack !== exp_ack) begin
      tests_failed++;
      $display("FAIL ack_pulse got=%b want=%b", bus_if.req_ack, exp_ack);
    end
    bus_if.req = req_after;
    bus_if.done_serializer = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({bus_if.req_ack, bus_if.grant, bus_if.busy} !== {{N{1'b0}}, {N{1'b0}}, 1'b0}) begin
      tests_failed++;
      $display("FAIL recover_clear got ack=%b grant=%b busy=%b want 0", bus_if.req_ack, bus_if.grant, bus_if.busy);
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.req = '0;
    bus_if.done_serializer = 1'b0;
    bus_if.req_data = '0;
    bus_if.req_dst_addr = '0;
    bus_if.req_ttl = '0;
    bus_if.req_router_id = '0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus_if.grant, bus_if.req_ack, bus_if.busy, bus_if.send_data_valid, bus_if.dst_addr_send,
         bus_if.TTL_send, bus_if.router_id_send, bus_if.v_data_read} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs got grant=%b ack=%b busy=%b sdv=%b want all 0",
               bus_if.grant, bus_if.req_ack, bus_if.busy, bus_if.send_data_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_single();
    set_src(2, 10'h155, 2'd2, 2'd1);
    bus_if.req = 4'b0100;
    push_exp(2, 10'h155, 2'd2, 2'd1);
    @(negedge clk);
    tests_run++;
    if ({bus_if.send_data_valid, bus_if.grant} !== {1'b1, 4'b0100}) begin
      tests_failed++;
      $display("FAIL single_latency got sdv=%b grant=%b want sdv=1 grant=0100", bus_if.send_data_valid, bus_if.grant);
    end
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if ({bus_if.busy, bus_if.req_ack, bus_if.dst_addr_send} !== {1'b1, 4'b0000, 10'h155}) begin
        tests_failed++;
        $display("FAIL single_wait got busy=%b ack=%b addr=%h want busy=1 ack=0000 addr=155",
                 bus_if.busy, bus_if.req_ack, bus_if.dst_addr_send);
      end
    end
    finish_job(4'b0100, 4'b0000);
  endtask
  task automatic test_skip_wrap();
    set_src(0, 10'h0A1, 2'd1, 2'd3);
    set_src(1, 10'h2B2, 2'd3, 2'd0);
    bus_if.req = 4'b0011;
    push_exp(0, 10'h0A1, 2'd1, 2'd3);
    wait_launch(ok);
    tests_run++;
    if ({ok, bus_if.grant} !== {1'b1, 4'b0001}) begin
      tests_failed++;
      $display("FAIL wrap_grant got launched=%b grant=%b want launched=1 grant=0001", ok, bus_if.grant);
    end
    finish_job(4'b0001, 4'b0010);
    push_exp(1, 10'h2B2, 2'd3, 2'd0);
    wait_launch(ok);
    tests_run++;
    if ({ok, bus_if.grant} !== {1'b1, 4'b0010}) begin
      tests_failed++;
      $display("FAIL skip_grant got launched=%b grant=%b want launched=1 grant=0010", ok, bus_if.grant);
    end
    finish_job(4'b0010, 4'b0000);
  endtask
  task automatic test_fairness();
    logic [N-1:0] g;
    apply_reset();
    for (int i = 0; i < N; i++) set_src(i, AW'(10'h100 + i), 2'(i), 2'(3 - i));
    for (int k = 0; k < 8; k++) push_exp(k % N, AW'(10'h100 + k % N), 2'(k % N), 2'(3 - k % N));
    bus_if.req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_launch(ok);
      g = '0;
      g[k % N] = 1'b1;
      tests_run++;
      if ({ok, bus_if.grant} !== {1'b1, g}) begin
        tests_failed++;
        $display("FAIL fair_order job=%0d got launched=%b grant=%b want grant=%b", k, ok, bus_if.grant, g);
      end
      if (k > 0) begin
        tests_run++;
        if (cyc_cnt - done_cyc < 3) begin
          tests_failed++;
          $display("FAIL fair_gap job=%0d got gap=%0d want >=3", k, cyc_cnt - done_cyc);
        end
      end
      finish_job(g, k == 7 ? 4'b0000 : 4'b1111);
    end
  endtask
  task automatic test_sticky_done();
    apply_reset();
    set_src(0, 10'h011, 2'd1, 2'd1);
    set_src(1, 10'h322, 2'd2, 2'd2);
    push_exp(0, 10'h011, 2'd1, 2'd1);
    push_exp(1, 10'h322, 2'd2, 2'd2);
    bus_if.req = 4'b0011;
    wait_launch(ok);
    bus_if.done_serializer = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.req_ack !== 4'b0001) begin
      tests_failed++;
      $display("FAIL sticky_ack1 got=%b want=0001", bus_if.req_ack);
    end
    bus_if.req = 4'b0010;
    wait_launch(ok);
    repeat (4) begin
      @(negedge clk);
      tests_run++;
      if ({ok, bus_if.busy, bus_if.req_ack} !== {1'b1, 1'b1, 4'b0000}) begin
        tests_failed++;
        $display("FAIL sticky_level got launched=%b busy=%b ack=%b want 1 1 0000", ok, bus_if.busy, bus_if.req_ack);
      end
    end
    bus_if.done_serializer = 1'b0;
    @(negedge clk);
    bus_if.done_serializer = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.req_ack !== 4'b0010) begin
      tests_failed++;
      $display("FAIL sticky_rerise got=%b want=0010", bus_if.req_ack);
    end
    bus_if.req = '0;
    bus_if.done_serializer = 1'b0;
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid_wait();
    apply_reset();
    set_src(3, 10'h3F0, 2'd3, 2'd2);
    push_exp(3, 10'h3F0, 2'd3, 2'd2);
    bus_if.req = 4'b1000;
    wait_launch(ok);
    repeat (5) begin
      @(negedge clk);
      tests_run++;
      if (bus_if.req_ack !== 4'b0000) begin
        tests_failed++;
        $display("FAIL abort_noack got=%b want=0000", bus_if.req_ack);
      end
    end
    rst_n = 1'b0;
    bus_if.req = '0;
    #1;
    tests_run++;
    if ({bus_if.grant, bus_if.req_ack, bus_if.busy, bus_if.send_data_valid, bus_if.dst_addr_send,
         bus_if.TTL_send, bus_if.router_id_send, bus_if.v_data_read} !== '0) begin
      tests_failed++;
      $display("FAIL abort_clear got grant=%b busy=%b addr=%h want all 0", bus_if.grant, bus_if.busy, bus_if.dst_addr_send);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_src(0, 10'h0C3, 2'd0, 2'd1);
    push_exp(0, 10'h0C3, 2'd0, 2'd1);
    bus_if.req = 4'b0001;
    wait_launch(ok);
    tests_run++;
    if ({ok, bus_if.grant} !== {1'b1, 4'b0001}) begin
      tests_failed++;
      $display("FAIL abort_regrant got launched=%b grant=%b want 1 0001", ok, bus_if.grant);
    end
    finish_job(4'b0001, 4'b0000);
  endtask
`ifdef SERARB_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    apply_reset();
    set_src(0, 10'h1E1, 2'd2, 2'd3);
    push_exp(0, 10'h1E1, 2'd2, 2'd3);
    bus_if.req = 4'b0001;
    wait_launch(ok);
    k = 0;
    while (k < 100 && bus_if.timeout_err !== 1'b1) begin
      @(negedge clk);
      k++;
      if (bus_if.req_ack !== 4'b0000) begin
        tests_run++;
        tests_failed++;
        $display("FAIL timeout_noack got=%b want=0000", bus_if.req_ack);
      end
    end
    bus_if.req = '0;
    tests_run++;
    if (k != 64) begin
      tests_failed++;
      $display("FAIL timeout_delay got=%0d want=64", k);
    end
    @(negedge clk);
    tests_run++;
    if ({bus_if.timeout_err, bus_if.grant, bus_if.busy, bus_if.req_ack} !== '0) begin
      tests_failed++;
      $display("FAIL timeout_idle got err=%b grant=%b busy=%b want 0", bus_if.timeout_err, bus_if.grant, bus_if.busy);
    end
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog got=stuck want=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single();
    test_skip_wrap();
    test_fairness();
    test_sticky_done();
    test_reset_mid_wait();
`ifdef SERARB_TIMEOUT_EN
    test_timeout();
`endif
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain got=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
